// File: rtl/hex_scan_595_if.sv
// hex_scan_595_if -- bundle for the 74HC595 hex scanner.
//   Scan controls (master -> slave): i_en, i_value, i_dp, i_lz
//   Chain drive  (slave -> master): o_shcp, o_stcp, o_ds, o_oe, o_busy, o_frame
// The scanner sits on the slave modport; whatever feeds it uses master.
`timescale 1ns/1ps
interface hex_scan_595_if #(
   parameter int N_DIGITS = 4
);
   logic                  i_en;
   logic [4*N_DIGITS-1:0] i_value;
   logic [N_DIGITS-1:0]   i_dp;
   logic                  i_lz;
   logic                  o_shcp;
   logic                  o_stcp;
   logic                  o_ds;
   logic                  o_oe;
   logic                  o_busy;
   logic                  o_frame;

   modport master (
      output i_en, i_value, i_dp, i_lz,
      input  o_shcp, o_stcp, o_ds, o_oe, o_busy, o_frame
   );

   modport slave (
      input  i_en, i_value, i_dp, i_lz,
      output o_shcp, o_stcp, o_ds, o_oe, o_busy, o_frame
   );
endinterface

// File: rtl/hex_scan_595.sv
// hex_scan_595 -- multiplexed hex display scanner driving a 74HC595 chain.
// Each digit period: LOAD (build word), SHIFT (W = 8 + N_DIGITS bits, MSB
// first), LATCH (STCP pulse), DWELL (digit held lit). A frame is N_DIGITS
// digit periods; inputs are captured once per frame at digit 0's LOAD.
// Ports:
//   clk    -- system clock, rising edge
//   rst_n  -- asynchronous active-low reset
//   bus    -- hex_scan_595_if.slave: i_en, i_value, i_dp, i_lz in;
//             o_shcp, o_stcp, o_ds, o_oe (active low), o_busy, o_frame out
// All outputs come straight from registers.
`timescale 1ns/1ps
module hex_scan_595 #(
   parameter int N_DIGITS         = 4,
   parameter int SHIFT_DIV        = 4,
   parameter int DWELL            = 1024,
   parameter bit SEG_ACTIVE_LOW   = 1'b0,
   parameter bit ANODE_ACTIVE_LOW = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   hex_scan_595_if.slave bus
);
   localparam int W     = 8 + N_DIGITS;
   localparam int DIG_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int T_MAX = (DWELL > SHIFT_DIV) ? DWELL : SHIFT_DIV;
   localparam int T_W   = $clog2(T_MAX + 1);
   localparam int B_W   = $clog2(W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_LATCH,
      S_DWELL
   } state_t;

   state_t                state;
   logic [DIG_W-1:0]      dig;
   logic [T_W-1:0]        tmr;
   logic [B_W-1:0]        bit_idx;
   logic                  phase_hi;
   logic [W-2:0]          sreg;      // bits still to go; current bit sits in ds_q
   logic [4*N_DIGITS-1:0] sh_value;
   logic [N_DIGITS-1:0]   sh_dp;
   logic                  sh_lz;
   logic                  shcp_q, stcp_q, ds_q, oe_q, busy_q, frame_q;

   // Word construction
   logic [4*N_DIGITS-1:0] src_value;
   logic [N_DIGITS-1:0]   src_dp;
   logic                  src_lz;
   logic [3:0]            nib;
   logic [6:0]            seg7;
   logic                  blank;
   logic [7:0]            seg;
   logic [N_DIGITS-1:0]   an;
   logic [W-1:0]          word;

   always_comb begin
      // Digit 0 builds from the live inputs: the shadows load on that same
      // edge, so reading them here would show the previous frame's value.
      if (dig == '0) begin
         src_value = bus.i_value;
         src_dp    = bus.i_dp;
         src_lz    = bus.i_lz;
      end else begin
         src_value = sh_value;
         src_dp    = sh_dp;
         src_lz    = sh_lz;
      end
      nib = src_value[4*dig +: 4];
      case (nib)
         4'h0: seg7 = 7'h3F;
         4'h1: seg7 = 7'h06;
         4'h2: seg7 = 7'h5B;
         4'h3: seg7 = 7'h4F;
         4'h4: seg7 = 7'h66;
         4'h5: seg7 = 7'h6D;
         4'h6: seg7 = 7'h7D;
         4'h7: seg7 = 7'h07;
         4'h8: seg7 = 7'h7F;
         4'h9: seg7 = 7'h6F;
         4'hA: seg7 = 7'h77;
         4'hB: seg7 = 7'h7C;
         4'hC: seg7 = 7'h39;
         4'hD: seg7 = 7'h5E;
         4'hE: seg7 = 7'h79;
         default: seg7 = 7'h71;
      endcase
      // Blank when this nibble and everything above it is zero
      blank = src_lz && (dig != '0) && ((src_value >> (4*dig)) == '0);
      if (blank) seg7 = '0;
      seg = {src_dp[dig], seg7};
      an  = '0;
      an[dig] = 1'b1;
      if (SEG_ACTIVE_LOW)   seg = ~seg;
      if (ANODE_ACTIVE_LOW) an  = ~an;
      word = {seg, an};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         dig      <= '0;
         tmr      <= '0;
         bit_idx  <= '0;
         phase_hi <= 1'b0;
         sreg     <= '0;
         sh_value <= '0;
         sh_dp    <= '0;
         sh_lz    <= 1'b0;
         shcp_q   <= 1'b0;
         stcp_q   <= 1'b0;
         ds_q     <= 1'b0;
         oe_q     <= 1'b1;
         busy_q   <= 1'b0;
         frame_q  <= 1'b0;
      end else begin
         frame_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.i_en) begin
                  state  <= S_LOAD;
                  dig    <= '0;
                  busy_q <= 1'b1;
               end
            end
            S_LOAD: begin
               if (dig == '0) begin
                  sh_value <= bus.i_value;
                  sh_dp    <= bus.i_dp;
                  sh_lz    <= bus.i_lz;
               end
               sreg     <= word[W-2:0];
               ds_q     <= word[W-1];
               bit_idx  <= '0;
               tmr      <= '0;
               phase_hi <= 1'b0;
               shcp_q   <= 1'b0;
               state    <= S_SHIFT;
            end
            S_SHIFT: begin
               if (tmr == T_W'(SHIFT_DIV - 1)) begin
                  tmr <= '0;
                  if (!phase_hi) begin
                     phase_hi <= 1'b1;
                     shcp_q   <= 1'b1;
                  end else begin
                     phase_hi <= 1'b0;
                     shcp_q   <= 1'b0;
                     if (bit_idx == B_W'(W - 1)) begin
                        state  <= S_LATCH;
                        stcp_q <= 1'b1;
                        ds_q   <= 1'b0;
                     end else begin
                        bit_idx <= bit_idx + 1'b1;
                        ds_q    <= sreg[W-2];
                        sreg    <= {sreg[W-3:0], 1'b0};
                     end
                  end
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            S_LATCH: begin
               if (tmr == T_W'(SHIFT_DIV - 1)) begin
                  tmr    <= '0;
                  stcp_q <= 1'b0;
                  oe_q   <= 1'b0;
                  state  <= S_DWELL;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            S_DWELL: begin
               if (tmr == T_W'(DWELL - 1)) begin
                  tmr <= '0;
                  if (dig != DIG_W'(N_DIGITS - 1)) begin
                     dig   <= dig + 1'b1;
                     state <= S_LOAD;
                  end else begin
                     frame_q <= 1'b1;
                     dig     <= '0;
                     if (bus.i_en) begin
                        state <= S_LOAD;
                     end else begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        oe_q   <= 1'b1;
                     end
                  end
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_shcp  = shcp_q;
   assign bus.o_stcp  = stcp_q;
   assign bus.o_ds    = ds_q;
   assign bus.o_oe    = oe_q;
   assign bus.o_busy  = busy_q;
   assign bus.o_frame = frame_q;
endmodule

// File: tb/tb_hex_scan_595.sv
// tb_hex_scan_595 -- two scanners (normal and fully inverted polarity) fed the
// same stimulus, checked every cycle against a timeline model of the frame,
// plus literal checks on decoded chain words and frame timing.
`timescale 1ns/1ps
module tb_hex_scan_595;
   localparam int N     = 4;
   localparam int SD    = 1;
   localparam int DW    = 4;
   localparam int W     = 8 + N;
   localparam int SHCYC = 2 * SD * W;
   localparam int PER   = 1 + SHCYC + SD + DW;
   localparam int FRAME = N * PER;

   localparam logic [6:0] SEG7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic [4*N-1:0] value = '0;
   logic [N-1:0] dp = '0;
   logic lz = 1'b0;

   always #5 clk = ~clk;

   hex_scan_595_if #(.N_DIGITS(N)) bus0 ();
   hex_scan_595_if #(.N_DIGITS(N)) bus1 ();

   assign bus0.i_en = en;  assign bus0.i_value = value;  assign bus0.i_dp = dp;  assign bus0.i_lz = lz;
   assign bus1.i_en = en;  assign bus1.i_value = value;  assign bus1.i_dp = dp;  assign bus1.i_lz = lz;

   hex_scan_595 #(.N_DIGITS(N), .SHIFT_DIV(SD), .DWELL(DW),
                  .SEG_ACTIVE_LOW(1'b0), .ANODE_ACTIVE_LOW(1'b0))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   hex_scan_595 #(.N_DIGITS(N), .SHIFT_DIV(SD), .DWELL(DW),
                  .SEG_ACTIVE_LOW(1'b1), .ANODE_ACTIVE_LOW(1'b1))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   int n_checks = 0;
   int n_errs = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- model: position on the frame timeline ----------------
   bit       m_run;
   int       m_pos;
   bit       m_oe;
   bit       m_frame;
   logic [4*N-1:0] m_val;
   logic [N-1:0]   m_dp;
   bit       m_lz;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run = 0; m_pos = 0; m_oe = 1; m_frame = 0; m_val = '0; m_dp = '0; m_lz = 0;
      end else begin
         m_frame = 0;
         if (!m_run) begin
            if (en) begin m_run = 1; m_pos = 0; end
         end else begin
            if (m_pos == 0) begin m_val = value; m_dp = dp; m_lz = lz; end
            m_pos++;
            if (m_pos % PER == 1 + SHCYC + SD) m_oe = 0;
            if (m_pos == FRAME) begin
               m_frame = 1;
               m_pos = 0;
               if (!en) begin m_run = 0; m_oe = 1; end
            end
         end
      end
   end

   function automatic logic [W-1:0] mk_word(input int d, input bit inv);
      logic [6:0] s;
      logic [7:0] sg;
      logic [N-1:0] an;
      s = SEG7[m_val[4*d +: 4]];
      if (m_lz && d > 0 && (m_val >> (4*d)) == 0) s = '0;
      sg = {m_dp[d], s};
      an = N'(1) << d;
      if (inv) begin sg = ~sg; an = ~an; end
      return {sg, an};
   endfunction

   // {busy, frame, oe, shcp, stcp, ds}
   function automatic logic [5:0] model_outs(input bit inv);
      int dig, k, j;
      logic [W-1:0] w;
      logic shcp, stcp, ds;
      shcp = 0; stcp = 0; ds = 0;
      if (!m_run) return {1'b0, m_frame, m_oe, 3'b000};
      dig = m_pos / PER;
      k = m_pos % PER;
      if (k >= 1 && k <= SHCYC) begin
         j = k - 1;
         shcp = ((j / SD) % 2) == 1;
         w = mk_word(dig, inv);
         ds = w[W - 1 - j / (2 * SD)];
      end else if (k > SHCYC && k <= SHCYC + SD) begin
         stcp = 1;
      end
      return {1'b1, m_frame, m_oe, shcp, stcp, ds};
   endfunction

   // ---------------- per-cycle compare + chain decoder ----------------
   logic [W-1:0] sh [2];
   int           nbits [2];
   bit           pshcp [2];
   bit           pstcp [2];
   logic [W-1:0] q0 [$];
   logic [W-1:0] q1 [$];
   int           rise0 = 0;
   logic [5:0]   got_o, exp_o;

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            sh[k] = '0; nbits[k] = 0; pshcp[k] = 0; pstcp[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (k == 0) got_o = {bus0.o_busy, bus0.o_frame, bus0.o_oe, bus0.o_shcp, bus0.o_stcp, bus0.o_ds};
            else        got_o = {bus1.o_busy, bus1.o_frame, bus1.o_oe, bus1.o_shcp, bus1.o_stcp, bus1.o_ds};
            exp_o = model_outs(k == 1);
            chk(k == 0 ? "cycle_outs_dut0" : "cycle_outs_dut1", 32'(got_o), 32'(exp_o));
            if (got_o[2] && !pshcp[k]) begin
               sh[k] = {sh[k][W-2:0], got_o[0]};
               nbits[k]++;
               if (k == 0) rise0++;
            end
            if (got_o[1] && !pstcp[k]) begin
               chk("latch_bits", 32'(nbits[k]), 32'(W));
               if (k == 0) q0.push_back(sh[k]); else q1.push_back(sh[k]);
               nbits[k] = 0;
            end
            pshcp[k] = got_o[2];
            pstcp[k] = got_o[1];
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_frame(output int n);
      bit seen;
      seen = 0;
      n = 0;
      while (!seen && n < 3 * FRAME) begin
         @(negedge clk);
         n++;
         if (bus0.o_frame) seen = 1;
      end
      if (!seen) chk("frame_timeout", 32'(0), 32'(1));
   endtask

   task automatic chk_words(input string name, input logic [W-1:0] e0, input logic [W-1:0] e1,
                            input logic [W-1:0] e2, input logic [W-1:0] e3);
      logic [W-1:0] e [4];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      chk({name, "_count"}, 32'(q0.size()), 32'(4));
      for (int i = 0; i < 4 && i < q0.size(); i++)
         chk($sformatf("%s_w%0d", name, i), 32'(q0[i]), 32'(e[i]));
   endtask

   task automatic chk_reset_outs(input string name);
      chk({name, "_dut0"}, 32'({bus0.o_busy, bus0.o_frame, bus0.o_oe, bus0.o_shcp, bus0.o_stcp, bus0.o_ds}),
          32'(6'b001000));
      chk({name, "_dut1"}, 32'({bus1.o_busy, bus1.o_frame, bus1.o_oe, bus1.o_shcp, bus1.o_stcp, bus1.o_ds}),
          32'(6'b001000));
   endtask

   int n, r;
   bit waited;

   initial begin
      // reset and idle
      tick(3);
      chk_reset_outs("reset_outs");
      rst_n = 1'b1;
      tick(3);
      chk("idle_busy", 32'(bus0.o_busy), 32'(0));

      // 0x1234, no dp, no blanking; frame timing
      value = 16'h1234; dp = '0; lz = 0;
      q0.delete(); q1.delete();
      r = rise0;
      en = 1;
      wait_frame(n);
      chk("frame_latency", 32'(n - 1), 32'(FRAME));
      chk("shcp_rises", 32'(rise0 - r), 32'(N * W));
      chk_words("w1234", 12'h661, 12'h4F2, 12'h5B4, 12'h068);

      // leading-zero blanking with dp on the top digit
      value = 16'h0050; lz = 1; dp = 4'b1000;
      q0.delete();
      wait_frame(n);
      chk_words("w0050", 12'h3F1, 12'h6D2, 12'h004, 12'h808);

      // value change mid-frame only shows next frame
      value = 16'h1234; lz = 0; dp = '0;
      q0.delete();
      tick(2 * PER + 5);
      value = 16'hFFFF;
      wait_frame(n);
      chk_words("midchg", 12'h661, 12'h4F2, 12'h5B4, 12'h068);
      q0.delete();
      wait_frame(n);
      chk_words("wFFFF", 12'h711, 12'h712, 12'h714, 12'h718);

      // disable during digit 1: frame completes, then idle
      tick(PER + 5);
      en = 0;
      wait_frame(n);
      chk("stop_busy", 32'(bus0.o_busy), 32'(0));
      chk("stop_oe", 32'(bus0.o_oe), 32'(1));
      r = rise0;
      tick(20);
      chk("idle_no_shcp", 32'(rise0 - r), 32'(0));
      value = 16'h0008; lz = 0; dp = '0;
      q0.delete(); q1.delete();
      en = 1;
      @(negedge clk);
      chk("restart_load", 32'(bus0.o_busy), 32'(1));
      waited = 0;
      for (int i = 0; i < 2 * PER && q1.size() == 0; i++) @(negedge clk);
      chk("inv_latched", 32'(q1.size() > 0), 32'(1));
      if (q1.size() > 0) chk("inv_word", 32'(q1[0]), 32'(12'h80E));
      if (q0.size() > 0) chk("norm_word8", 32'(q0[0]), 32'(12'h7F1));

      // async reset in the high phase of bit 5
      wait_frame(n);
      tick(12);
      chk("pre_reset_shcp", 32'(bus0.o_shcp), 32'(1));
      #2 rst_n = 1'b0;
      #1 chk_reset_outs("async_reset");
      tick(2);
      value = 16'h1234; dp = '0; lz = 0;
      q0.delete(); q1.delete();
      rst_n = 1'b1;
      wait_frame(n);
      chk("rst_frame_latency", 32'(n - 1), 32'(FRAME));
      chk_words("after_rst", 12'h661, 12'h4F2, 12'h5B4, 12'h068);

      // random traffic against the model
      for (int it = 0; it < 25; it++) begin
         tick($urandom_range(1, 150));
         value = 16'($urandom);
         dp = 4'($urandom);
         lz = 1'($urandom);
         en = ($urandom_range(0, 4) != 0);
      end
      en = 0;
      tick(2 * FRAME + 10);
      chk("final_idle", 32'(bus0.o_busy), 32'(0));

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end
endmodule
